// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types, imported by both the master command engine and the register slaves.
package axi4_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } axi4_resp_t;

   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle. The master port drives the VALIDs and payloads; the slave port drives the READYs and responses.
interface axi4_lite_if #(
   parameter int unsigned ADDR_BIT_WIDTH = 4,
   parameter int unsigned DATA_BIT_WIDTH = 32
) ();
   import axi4_lite_pkg::*;

   localparam int unsigned STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;

   logic                      awvalid;
   logic                      awready;
   logic [ADDR_BIT_WIDTH-1:0] awaddr;
   logic [2:0]                awprot;
   logic                      wvalid;
   logic                      wready;
   logic [DATA_BIT_WIDTH-1:0] wdata;
   logic [STRB_BIT_WIDTH-1:0] wstrb;
   logic                      bvalid;
   logic                      bready;
   axi4_resp_t                bresp;
   logic                      arvalid;
   logic                      arready;
   logic [ADDR_BIT_WIDTH-1:0] araddr;
   logic [2:0]                arprot;
   logic                      rvalid;
   logic                      rready;
   logic [DATA_BIT_WIDTH-1:0] rdata;
   axi4_resp_t                rresp;

   modport mst_port (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slv_port (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

endinterface

// File: rtl/my_axi4_lite_mst_cmd_engine.sv
// Single-outstanding AXI4-Lite master: turns one write/read command into one bus transaction
// and returns the result on a response port, keeping a saturating count of non-OKAY responses.
module my_axi4_lite_mst_cmd_engine
   import axi4_lite_pkg::*;
#(
   parameter int unsigned ADDR_BIT_WIDTH    = 4,
   parameter int unsigned DATA_BIT_WIDTH    = 32,
   parameter int unsigned ERR_CNT_BIT_WIDTH = 8
) (
   input  logic                           i_clk,
   input  logic                           i_sync_rst,
   input  logic                           i_cmd_valid,
   output logic                           o_cmd_ready,
   input  logic                           i_cmd_is_wr,
   input  logic [ADDR_BIT_WIDTH-1:0]      i_cmd_addr,
   input  logic [DATA_BIT_WIDTH-1:0]      i_cmd_wdata,
   input  logic [DATA_BIT_WIDTH/8-1:0]    i_cmd_wstrb,
   output logic                           o_rsp_valid,
   input  logic                           i_rsp_ready,
   output logic                           o_rsp_is_wr,
   output logic [DATA_BIT_WIDTH-1:0]      o_rsp_rdata,
   output axi4_resp_t                     o_rsp_resp,
   output logic [ERR_CNT_BIT_WIDTH-1:0]   o_err_cnt,
   axi4_lite_if.mst_port                  if_m_axi4_lite
);

   localparam int unsigned STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;

   if (ADDR_BIT_WIDTH != if_m_axi4_lite.ADDR_BIT_WIDTH) begin : g_addr_width_mismatch
      $error("ADDR_BIT_WIDTH does not match the AXI4-Lite interface");
   end
   if (DATA_BIT_WIDTH != if_m_axi4_lite.DATA_BIT_WIDTH) begin : g_data_width_mismatch
      $error("DATA_BIT_WIDTH does not match the AXI4-Lite interface");
   end

   typedef enum logic [2:0] {
      IDLE,
      WR_AW_W,
      WR_B,
      RD_AR,
      RD_R,
      RSP
   } state_t;

   state_t                    state;
   logic                      awvalid_r;
   logic                      wvalid_r;
   logic                      bready_r;
   logic                      arvalid_r;
   logic                      rready_r;
   logic [ADDR_BIT_WIDTH-1:0] addr_r;
   logic [DATA_BIT_WIDTH-1:0] wdata_r;
   logic [STRB_BIT_WIDTH-1:0] wstrb_r;

   logic                      aw_hs_c;
   logic                      w_hs_c;
   logic                      b_hs_c;
   logic                      ar_hs_c;
   logic                      r_hs_c;
   logic                      capture_c;
   axi4_resp_t                capture_resp_c;

   // Handshake decode; a response is captured on the B or R handshake of the active transaction.
   always_comb begin
      aw_hs_c        = awvalid_r && if_m_axi4_lite.awready;
      w_hs_c         = wvalid_r  && if_m_axi4_lite.wready;
      b_hs_c         = bready_r  && if_m_axi4_lite.bvalid;
      ar_hs_c        = arvalid_r && if_m_axi4_lite.arready;
      r_hs_c         = rready_r  && if_m_axi4_lite.rvalid;
      capture_c      = ((state == WR_B) && b_hs_c) || ((state == RD_R) && r_hs_c);
      capture_resp_c = (state == WR_B) ? if_m_axi4_lite.bresp : if_m_axi4_lite.rresp;
   end

   always_ff @(posedge i_clk) begin
      if (i_sync_rst) begin
         state       <= IDLE;
         o_cmd_ready <= 1'b1;
         awvalid_r   <= 1'b0;
         wvalid_r    <= 1'b0;
         bready_r    <= 1'b0;
         arvalid_r   <= 1'b0;
         rready_r    <= 1'b0;
         addr_r      <= '0;
         wdata_r     <= '0;
         wstrb_r     <= '0;
         o_rsp_valid <= 1'b0;
         o_rsp_is_wr <= 1'b0;
         o_rsp_rdata <= '0;
         o_rsp_resp  <= OKAY;
         o_err_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_cmd_valid && o_cmd_ready) begin
                  o_cmd_ready <= 1'b0;
                  addr_r      <= i_cmd_addr;
                  wdata_r     <= i_cmd_wdata;
                  wstrb_r     <= i_cmd_wstrb;
                  if (i_cmd_is_wr) begin
                     awvalid_r <= 1'b1;
                     wvalid_r  <= 1'b1;
                     state     <= WR_AW_W;
                  end else begin
                     arvalid_r <= 1'b1;
                     state     <= RD_AR;
                  end
               end
            end
            // AW and W complete independently; B is only accepted once both are done.
            WR_AW_W: begin
               if (aw_hs_c) awvalid_r <= 1'b0;
               if (w_hs_c)  wvalid_r  <= 1'b0;
               if ((!awvalid_r || aw_hs_c) && (!wvalid_r || w_hs_c)) begin
                  bready_r <= 1'b1;
                  state    <= WR_B;
               end
            end
            WR_B: begin
               if (b_hs_c) begin
                  bready_r    <= 1'b0;
                  o_rsp_valid <= 1'b1;
                  o_rsp_is_wr <= 1'b1;
                  o_rsp_rdata <= '0;
                  o_rsp_resp  <= if_m_axi4_lite.bresp;
                  state       <= RSP;
               end
            end
            RD_AR: begin
               if (ar_hs_c) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
                  state     <= RD_R;
               end
            end
            RD_R: begin
               if (r_hs_c) begin
                  rready_r    <= 1'b0;
                  o_rsp_valid <= 1'b1;
                  o_rsp_is_wr <= 1'b0;
                  o_rsp_rdata <= if_m_axi4_lite.rdata;
                  o_rsp_resp  <= if_m_axi4_lite.rresp;
                  state       <= RSP;
               end
            end
            RSP: begin
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
                  o_cmd_ready <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (capture_c && (capture_resp_c != OKAY) && (o_err_cnt != '1)) begin
            o_err_cnt <= o_err_cnt + ERR_CNT_BIT_WIDTH'(1);
         end
      end
   end

   assign if_m_axi4_lite.awvalid = awvalid_r;
   assign if_m_axi4_lite.awaddr  = addr_r;
   assign if_m_axi4_lite.awprot  = AXI_PROT_DEFAULT;
   assign if_m_axi4_lite.wvalid  = wvalid_r;
   assign if_m_axi4_lite.wdata   = wdata_r;
   assign if_m_axi4_lite.wstrb   = wstrb_r;
   assign if_m_axi4_lite.bready  = bready_r;
   assign if_m_axi4_lite.arvalid = arvalid_r;
   assign if_m_axi4_lite.araddr  = addr_r;
   assign if_m_axi4_lite.arprot  = AXI_PROT_DEFAULT;
   assign if_m_axi4_lite.rready  = rready_r;

endmodule

// File: tb/tb_my_axi4_lite_mst_cmd_engine.sv
// Directed bench: the command engine driving a behavioural 4-register AXI4-Lite slave
// with adjustable ready delays and an error-response mode.
module tb_my_axi4_lite_mst_cmd_engine;
   import axi4_lite_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_is_wr = 1'b0;
   logic [3:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic        rsp_is_wr;
   logic [31:0] rsp_rdata;
   axi4_resp_t  rsp_resp;
   logic [7:0]  err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // slave knobs
   int aw_delay = 0;
   int w_delay  = 0;
   int ar_delay = 0;
   bit err_mode = 1'b0;

   axi4_lite_if #(.ADDR_BIT_WIDTH(4), .DATA_BIT_WIDTH(32)) axi ();

   my_axi4_lite_mst_cmd_engine #(
      .ADDR_BIT_WIDTH(4), .DATA_BIT_WIDTH(32), .ERR_CNT_BIT_WIDTH(8)
   ) dut (
      .i_clk(clk), .i_sync_rst(rst),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_is_wr(cmd_is_wr),
      .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_is_wr(rsp_is_wr),
      .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp), .o_err_cnt(err_cnt),
      .if_m_axi4_lite(axi)
   );

   always #5 clk = ~clk;

   // Behavioural slave: four 32-bit registers at byte addresses 0x0/0x4/0x8/0xC.
   logic [31:0] regs [4];
   logic        aw_got, w_got;
   logic [3:0]  aw_addr_l;
   logic [31:0] w_data_l;
   logic [3:0]  w_strb_l;
   int          aw_cnt, w_cnt, ar_cnt;
   int          b_hs_cnt = 0;

   assign axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_delay);
   assign axi.wready  = axi.wvalid  && !w_got  && (w_cnt  >= w_delay);
   assign axi.arready = axi.arvalid && !axi.rvalid && (ar_cnt >= ar_delay);

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
         aw_got <= 1'b0; w_got <= 1'b0;
         aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         axi.bvalid <= 1'b0; axi.bresp <= OKAY;
         axi.rvalid <= 1'b0; axi.rresp <= OKAY; axi.rdata <= '0;
      end else begin
         if (axi.awvalid && axi.awready) begin
            aw_got <= 1'b1; aw_addr_l <= axi.awaddr; aw_cnt <= 0;
         end else if (axi.awvalid && !aw_got) aw_cnt <= aw_cnt + 1;
         if (axi.wvalid && axi.wready) begin
            w_got <= 1'b1; w_data_l <= axi.wdata; w_strb_l <= axi.wstrb; w_cnt <= 0;
         end else if (axi.wvalid && !w_got) w_cnt <= w_cnt + 1;
         if (aw_got && w_got && !axi.bvalid) begin
            for (int b = 0; b < 4; b++)
               if (w_strb_l[b]) regs[aw_addr_l[3:2]][8*b +: 8] <= w_data_l[8*b +: 8];
            aw_got <= 1'b0; w_got <= 1'b0;
            axi.bvalid <= 1'b1; axi.bresp <= OKAY;
         end else if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
         if (axi.arvalid && axi.arready) begin
            axi.rvalid <= 1'b1;
            axi.rdata  <= regs[axi.araddr[3:2]];
            axi.rresp  <= err_mode ? SLVERR : OKAY;
            ar_cnt     <= 0;
         end else begin
            if (axi.arvalid) ar_cnt <= ar_cnt + 1;
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
         end
         if (axi.bvalid && axi.bready) b_hs_cnt <= b_hs_cnt + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Presents one command at a negedge; returns at the negedge after its handshake.
   task automatic issue_cmd(input logic wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      check_eq("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_is_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Waits (bounded) for a response; consumes it if rsp_ready is high.
   task automatic wait_rsp(output logic rwr, output logic [31:0] rd, output logic [1:0] rr, output logic [7:0] ec);
      int n = 0;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) check_eq("rsp_timeout", 64'(rsp_valid), 64'd1);
      rwr = rsp_is_wr; rd = rsp_rdata; rr = rsp_resp; ec = err_cnt;
      if (rsp_ready) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        rwr;
      logic [31:0] rd;
      logic [1:0]  rr;
      logic [7:0]  ec;
      int          b_before;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check_eq("rst_awvalid", 64'(axi.awvalid), 64'd0);
      check_eq("rst_wvalid", 64'(axi.wvalid), 64'd0);
      check_eq("rst_arvalid", 64'(axi.arvalid), 64'd0);
      check_eq("rst_bready", 64'(axi.bready), 64'd0);
      check_eq("rst_rready", 64'(axi.rready), 64'd0);
      check_eq("rst_awaddr", 64'(axi.awaddr), 64'd0);
      check_eq("rst_wdata", 64'(axi.wdata), 64'd0);
      check_eq("rst_wstrb", 64'(axi.wstrb), 64'd0);
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);

      // 1: write then read back
      issue_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
      check_eq("t1_awaddr", 64'(axi.awaddr), 64'h4);
      check_eq("t1_awprot", 64'(axi.awprot), 64'd0);
      wait_rsp(rwr, rd, rr, ec);
      check_eq("t1_wr_is_wr", 64'(rwr), 64'd1);
      check_eq("t1_wr_resp", 64'(rr), 64'd0);
      check_eq("t1_wr_rdata", 64'(rd), 64'd0);
      issue_cmd(1'b0, 4'h4, 32'h0, 4'h0);
      wait_rsp(rwr, rd, rr, ec);
      check_eq("t1_rd_is_wr", 64'(rwr), 64'd0);
      check_eq("t1_rd_rdata", 64'(rd), 64'hDEADBEEF);
      check_eq("t1_rd_resp", 64'(rr), 64'd0);
      check_eq("t1_err_cnt", 64'(ec), 64'd0);

      // 2: partial strobe write
      issue_cmd(1'b1, 4'h8, 32'h0, 4'hF);
      wait_rsp(rwr, rd, rr, ec);
      issue_cmd(1'b1, 4'h8, 32'h12345678, 4'h3);
      wait_rsp(rwr, rd, rr, ec);
      issue_cmd(1'b0, 4'h8, 32'h0, 4'h0);
      wait_rsp(rwr, rd, rr, ec);
      check_eq("t2_rd_rdata", 64'(rd), 64'h00005678);

      // 3: W accepted three cycles before AW
      aw_delay = 3; w_delay = 0;
      b_before = b_hs_cnt;
      issue_cmd(1'b1, 4'hC, 32'hA5A5_5A5A, 4'hF);
      check_eq("t3_c0_awvalid", 64'(axi.awvalid), 64'd1);
      check_eq("t3_c0_wvalid", 64'(axi.wvalid), 64'd1);
      @(negedge clk);
      check_eq("t3_c1_wvalid", 64'(axi.wvalid), 64'd0);
      check_eq("t3_c1_awvalid", 64'(axi.awvalid), 64'd1);
      @(negedge clk);
      check_eq("t3_c2_awvalid", 64'(axi.awvalid), 64'd1);
      @(negedge clk);
      check_eq("t3_c3_awvalid", 64'(axi.awvalid), 64'd1);
      check_eq("t3_c3_bready", 64'(axi.bready), 64'd0);
      @(negedge clk);
      check_eq("t3_c4_awvalid", 64'(axi.awvalid), 64'd0);
      check_eq("t3_c4_bready", 64'(axi.bready), 64'd1);
      wait_rsp(rwr, rd, rr, ec);
      check_eq("t3_wr_resp", 64'(rr), 64'd0);
      check_eq("t3_b_count", 64'(b_hs_cnt - b_before), 64'd1);
      aw_delay = 0;
      issue_cmd(1'b0, 4'hC, 32'h0, 4'h0);
      wait_rsp(rwr, rd, rr, ec);
      check_eq("t3_rd_rdata", 64'(rd), 64'hA5A5_5A5A);

      // 4: error responses saturate the counter
      err_mode = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         issue_cmd(1'b0, 4'h0, 32'h0, 4'h0);
         wait_rsp(rwr, rd, rr, ec);
         check_eq("t4_resp", 64'(rr), 64'd2);
         check_eq("t4_err_cnt", 64'(ec), (i > 255) ? 64'd255 : 64'(i));
      end
      err_mode = 1'b0;

      // 5: response back-pressure
      rsp_ready = 1'b0;
      issue_cmd(1'b0, 4'h4, 32'h0, 4'h0);
      wait_rsp(rwr, rd, rr, ec);
      for (int i = 0; i < 5; i++) begin
         check_eq("t5_rsp_valid", 64'(rsp_valid), 64'd1);
         check_eq("t5_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
         check_eq("t5_rsp_resp", 64'(rsp_resp), 64'd0);
         check_eq("t5_cmd_ready", 64'(cmd_ready), 64'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("t5_after_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("t5_after_cmd_ready", 64'(cmd_ready), 64'd1);

      // 6: reset while ARVALID is pending
      ar_delay = 50;
      issue_cmd(1'b0, 4'h4, 32'h0, 4'h0);
      check_eq("t6_arvalid_pending", 64'(axi.arvalid), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("t6_rst_arvalid", 64'(axi.arvalid), 64'd0);
      check_eq("t6_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check_eq("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("t6_rst_err_cnt", 64'(err_cnt), 64'd0);
      ar_delay = 0;
      rst = 1'b0;
      @(negedge clk);
      issue_cmd(1'b0, 4'h0, 32'h0, 4'h0);
      wait_rsp(rwr, rd, rr, ec);
      check_eq("t6_rd_rdata", 64'(rd), 64'h0);
      check_eq("t6_rd_resp", 64'(rr), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
